// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, device-clocked shift-out, ack check.
// Optional retry on failure is enabled by defining PS2_TX_RESEND_EN (adds the retry_cnt port).
module ps2_host_tx #(
  parameter int unsigned SYSCLK_FREQUENCY_HZ = 108000000,
  parameter int unsigned INHIBIT_US          = 100,
  parameter int unsigned START_TIMEOUT_MS    = 15,
  parameter int unsigned FRAME_TIMEOUT_MS    = 2,
  parameter int unsigned FILTER_LEN          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
`ifdef PS2_TX_RESEND_EN
  ,
  output logic [1:0] retry_cnt
`endif
);

  localparam int unsigned INHIBIT_CYC = (SYSCLK_FREQUENCY_HZ / 1000000) * INHIBIT_US;
  localparam int unsigned START_CYC   = (SYSCLK_FREQUENCY_HZ / 1000) * START_TIMEOUT_MS;
  localparam int unsigned FRAME_CYC   = (SYSCLK_FREQUENCY_HZ / 1000) * FRAME_TIMEOUT_MS;
  localparam int unsigned MAX_SF      = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
  localparam int unsigned CNT_MAX     = (INHIBIT_CYC > MAX_SF) ? INHIBIT_CYC : MAX_SF;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
  localparam int unsigned FLT_W       = $clog2(FILTER_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] INH_PRE   = CNT_W'(INHIBIT_CYC - 2);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_CYC);
  localparam logic [CNT_W-1:0] FRAME_LIM = CNT_W'(FRAME_CYC);
  localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FILTER_LEN - 1);
  localparam logic             DATA_AT_ACCEPT = (INHIBIT_CYC <= 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_SHIFT     = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_filt_q, clk_filt_d, clk_prev_q;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             clk_s, data_s, clk_fall;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
  logic [7:0]       byte_q, byte_d;
  logic [8:0]       frame_q, frame_d;
  logic [3:0]       bits_q, bits_d;
  logic             clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic             ack_q, ack_d;
  logic             done_p, err_p, fail;
`ifdef PS2_TX_RESEND_EN
  logic [1:0]       retry_q, retry_d;
`endif

  assign clk_s    = clk_sync_q[1];
  assign data_s   = data_sync_q[1];
  assign clk_fall = clk_prev_q & ~clk_filt_q;
  assign cnt_sat  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

  // A level change is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    flt_cnt_d  = '0;
    clk_filt_d = clk_filt_q;
    if (clk_s != clk_filt_q) begin
      if (flt_cnt_q == FLT_LAST) clk_filt_d = clk_s;
      else                       flt_cnt_d  = flt_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    frame_d   = frame_q;
    bits_d    = bits_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    done_p    = 1'b0;
    err_p     = 1'b0;
    fail      = 1'b0;
`ifdef PS2_TX_RESEND_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bits_d = '0;
`ifdef PS2_TX_RESEND_EN
        retry_d = '0;
`endif
        if (tx_valid) begin
          byte_d    = tx_data;
          frame_d   = {~^tx_data, tx_data};
          cnt_d     = '0;
          clk_oe_d  = 1'b1;
          data_oe_d = DATA_AT_ACCEPT;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INH_PRE) data_oe_d = 1'b1;
        if (cnt_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        cnt_d = cnt_sat;
        if (cnt_q >= START_LIM) fail = 1'b1;
        else if (clk_fall) begin
          data_oe_d = ~frame_q[0];
          frame_d   = {1'b1, frame_q[8:1]};
          bits_d    = 4'd1;
          cnt_d     = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_sat;
        if (cnt_q >= FRAME_LIM) fail = 1'b1;
        else if (clk_fall) begin
          if (bits_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end else begin
            data_oe_d = ~frame_q[0];
            frame_d   = {1'b1, frame_q[8:1]};
            bits_d    = bits_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        cnt_d = cnt_sat;
        if (cnt_q >= FRAME_LIM) fail = 1'b1;
        else if (clk_fall) begin
          ack_d   = ~data_s;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        cnt_d = cnt_sat;
        if (cnt_q >= FRAME_LIM) fail = 1'b1;
        else if (clk_filt_q && data_s) begin
          if (ack_q) begin
            done_p  = 1'b1;
            state_d = S_IDLE;
          end else begin
            fail = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Expiry is checked before edges above, so a coincident edge loses.
    if (fail) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      cnt_d     = '0;
      state_d   = S_IDLE;
`ifdef PS2_TX_RESEND_EN
      if (retry_q != 2'd2) begin
        retry_d   = retry_q + 2'd1;
        frame_d   = {~^byte_q, byte_q};
        clk_oe_d  = 1'b1;
        data_oe_d = DATA_AT_ACCEPT;
        state_d   = S_INHIBIT;
      end else begin
        err_p = 1'b1;
      end
`else
      err_p = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_filt_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      flt_cnt_q   <= '0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      byte_q      <= '0;
      frame_q     <= '0;
      bits_q      <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      ack_q       <= 1'b0;
`ifdef PS2_TX_RESEND_EN
      retry_q     <= '0;
`endif
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_filt_q  <= clk_filt_d;
      clk_prev_q  <= clk_filt_q;
      flt_cnt_q   <= flt_cnt_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      frame_q     <= frame_d;
      bits_q      <= bits_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      ack_q       <= ack_d;
`ifdef PS2_TX_RESEND_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign tx_busy     = (state_q != S_IDLE);
  assign tx_done     = done_p;
  assign tx_error    = err_p;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
`ifdef PS2_TX_RESEND_EN
  assign retry_cnt   = retry_q;
`endif

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 command transmitter: the sending side of the PS/2 link whose receive side (device-to-host packet decode) already lives in the mouse path.
- Sends one byte to the attached device, e.g. 0xF4 enable reporting, 0xFF reset, 0xF3 set sample rate. It performs the full PS/2 request-to-send sequence, then shifts the frame on device-generated clocks and checks the device acknowledge.
- Sits beside the mouse controller at the top level. Both share the PS2_CLK/PS2_DATA pads through an open-drain mux.
- Runs in the 108 MHz pixel/system clock domain.

Parameters:
- SYSCLK_FREQUENCY_HZ, 108000000, system clock frequency used to derive all timers.
- INHIBIT_US, 100, time ps2_clk is held low before the start bit.
- START_TIMEOUT_MS, 15, maximum wait from clock release to the first device falling edge.
- FRAME_TIMEOUT_MS, 2, maximum time from the first device falling edge to the end of acknowledge.
- FILTER_LEN, 8, consecutive equal synchronized samples required to accept a ps2_clk level change.

Ports:
- clk  in  1  system clock, 108 MHz.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; the byte is accepted on tx_valid && tx_ready.
- tx_busy  out  1  high from accept until return to IDLE.
- tx_done  out  1  one-cycle pulse when the device acknowledges.
- tx_error  out  1  one-cycle pulse on timeout or missing acknowledge.
- ps2_clk_i  in  1  raw PS2_CLK pad level.
- ps2_data_i  in  1  raw PS2_DATA pad level.
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release. The top level ties the pad to 0 when oe is 1, otherwise high-Z.
- ps2_data_oe  out  1  same scheme for PS2_DATA.

Behaviour:
- Reset: all outputs 0 except tx_ready=1. State is IDLE, both lines are released, counters are cleared. Reset mid-frame releases both lines on the first reset edge and drops the frame silently (no tx_error).
- Input conditioning:
  - ps2_clk_i and ps2_data_i pass through 2-flop synchronizers.
  - ps2_clk is then glitch-filtered over FILTER_LEN samples.
  - Falling edge = filtered clk goes 1->0.
- Accept: on tx_valid && tx_ready the module latches tx_data, computes the odd parity bit (~^tx_data), and goes IDLE->INHIBIT. tx_valid is ignored outside IDLE.
- INHIBIT:
  - ps2_clk_oe=1 for INHIBIT_US (10800 cycles at default).
  - ps2_data_oe goes to 1 in the last cycle of INHIBIT.
  - Then -> START.
- START:
  - ps2_clk_oe=0, ps2_data_oe stays 1 (start bit = 0).
  - Waits for the first falling edge, with the START_TIMEOUT counter running.
  - On that edge -> SHIFT with bit index 0.
- SHIFT: on each falling edge n (n=1..10) data is updated while the clock is low:
  - Edges 1-8: ps2_data_oe = ~data[n-1] (LSB first).
  - Edge 9: ps2_data_oe = ~parity.
  - Edge 10: ps2_data_oe=0 (stop bit), then -> ACK.
- ACK:
  - Samples synchronized data at the 11th falling edge: 0 = acknowledge ok, 1 = no acknowledge.
  - Then -> WAIT_IDLE.
- WAIT_IDLE:
  - Waits until filtered clk=1 and data=1.
  - Then pulses tx_done (ack ok) or tx_error (no ack) and returns to IDLE.
  - tx_ready rises in the cycle after the pulse.
- Timeouts:
  - START_TIMEOUT and FRAME_TIMEOUT counters saturate.
  - On expiry in START/SHIFT/ACK/WAIT_IDLE: release both lines, pulse tx_error, go to IDLE.
  - If a falling edge and an expiry occur in the same cycle, expiry wins.
- Lines never drive high. ps2_clk_oe is 1 only in INHIBIT.
- Simultaneous tx_valid and done/error pulse: tx_valid is not accepted, because tx_ready=0 that cycle.

Optional Feature:
- Macro PS2_TX_RESEND_EN.
- Defined:
  - A missing acknowledge or timeout re-enters INHIBIT with the same latched byte, up to 2 retries.
  - tx_error pulses only after the 3rd failed attempt.
  - tx_busy stays high throughout.
  - Output retry_cnt[1:0] is added, showing the attempt number (0-2) and cleared in IDLE.
- Undefined: no retry and no retry_cnt port; the first failure pulses tx_error.

Test Plan:
- Bench uses a device-model clock of 12.5 kHz, INHIBIT_US=2, START_TIMEOUT_MS=1, FRAME_TIMEOUT_MS=2 for short sim runs.
- Send 0xF4 with ack: ps2_clk_oe high for exactly INHIBIT cycles. Device samples bits 0,0,1,0,1,1,1,1, parity 0, stop 1. tx_done pulses once and tx_ready returns 1.
- Send 0xFF with ack: device samples parity bit 1. tx_done=1, tx_error never asserted.
- Device never clocks after request: tx_error pulses after START_TIMEOUT, both oe=0. With PS2_TX_RESEND_EN, 3 INHIBIT phases occur before a single tx_error.
- Device clocks 11 edges but holds data high at the ack edge: tx_error pulse, tx_done stays 0.
- rst asserted after the 5th falling edge of a 0xF3 frame: next cycle both oe=0, tx_ready=1, no done/error pulse. A following 0xF4 completes normally.
- 1-cycle low glitches on ps2_clk_i mid-frame (FILTER_LEN=8): bit index unaffected and the frame completes with correct bits.
